// File: rtl/data_memory_unit.sv
// Data-side memory responder: byte-addressed little-endian RAM serving one
// RV32I load/store at a time. Accesses that cross a word boundary are split
// into two word accesses. Load data is returned left-justified.
module data_memory_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned LANES = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_DONE
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_rdata_q;
  logic              resp_err_q;

  // Latched request
  logic              we_q;
  logic              err_q;
  logic              cross_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] w0_idx_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   lo_q;

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

  // Request decode, evaluated on the live inputs at the accept edge
  logic [2:0]        req_nbytes;
  logic              req_cross;
  logic              req_illegal;
  logic              unused_addr_hi;

  // Access helpers for the latched request
  logic [ADDR_W-1:0] w1_idx;
  logic [7:0]        be_mask;
  logic [7:0]        be_win;
  logic [4:0]        lane_sh;
  logic [4:0]        just_sh;
  logic [2*XLEN-1:0] st_win;
  logic [2*XLEN-1:0] ld_win;
  logic [XLEN-1:0]   ld_val;
  logic [XLEN-1:0]   ld_just;
  logic [XLEN-1:0]   rd_word0;
  logic [XLEN-1:0]   rd_word1;
  logic              mem_we0;
  logic              mem_we1;

  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+2];

  // Decode size, legality and boundary crossing of the incoming request
  always_comb begin
    req_nbytes  = 3'd4;
    req_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_nbytes = 3'd1;
      3'b001, 3'b101: req_nbytes = 3'd2;
      3'b010:         req_nbytes = 3'd4;
      default:        req_illegal = 1'b1;
    endcase
    if (req_funct3[2] && req_we) begin
      req_illegal = 1'b1;
    end
    req_cross = (3'({1'b0, req_addr[1:0]}) + req_nbytes) > 3'd4;
  end

  // Byte enables, store data alignment and load data justification
  always_comb begin
    be_mask = 8'h0F;
    just_sh = 5'd0;
    case (size_q)
      2'b00: begin
        be_mask = 8'h01;
        just_sh = 5'd24;
      end
      2'b01: begin
        be_mask = 8'h03;
        just_sh = 5'd16;
      end
      default: begin
        be_mask = 8'h0F;
        just_sh = 5'd0;
      end
    endcase
    lane_sh  = {1'b0, lane_q, 2'b00} << 1;
    be_win   = be_mask << lane_q;
    st_win   = {{XLEN{1'b0}}, wdata_q} << lane_sh;
    w1_idx   = w0_idx_q + ADDR_W'(1);
    rd_word0 = mem_q[w0_idx_q];
    rd_word1 = mem_q[w1_idx];
    ld_win   = (state_q == ST_W1) ? {rd_word1, lo_q} : {{XLEN{1'b0}}, rd_word0};
    ld_val   = ld_win[lane_sh +: XLEN];
    ld_just  = ld_val << just_sh;
    mem_we0  = !reset && (state_q == ST_W0) && we_q && !err_q;
    mem_we1  = !reset && (state_q == ST_W1) && we_q && !err_q;
  end

  // RAM byte-lane writes; W0 uses the low window half, W1 the high half
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(LANES); b++) begin
      if (mem_we0 && be_win[b]) begin
        mem_q[w0_idx_q][8*b +: 8] <= st_win[8*b +: 8];
      end
      if (mem_we1 && be_win[LANES+b]) begin
        mem_q[w1_idx][8*b +: 8] <= st_win[XLEN+8*b +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      cross_q      <= 1'b0;
      lane_q       <= '0;
      size_q       <= '0;
      w0_idx_q     <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_W0;
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            err_q       <= req_illegal;
            cross_q     <= req_cross;
            lane_q      <= req_addr[1:0];
            size_q      <= req_funct3[1:0];
            w0_idx_q    <= req_addr[ADDR_W+1:2];
            wdata_q     <= req_wdata;
          end
        end
        ST_W0: begin
          // Illegal requests pass through W0 without touching the RAM
          lo_q <= rd_word0;
          if (err_q) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (cross_q) begin
            state_q <= ST_W1;
          end else begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? '0 : ld_just;
          end
        end
        ST_W1: begin
          state_q      <= ST_DONE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? '0 : ld_just;
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed vector table, reset
// corner sequence, then random traffic against a byte-array reference model.
module tb_data_memory_unit;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks;
  int errors;

  logic [7:0] ref_mem [NBYTES];

  data_memory_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: apply the access to the byte array, return expected response
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd,
                            output logic er, output int lat);
    int s;
    int a;
    logic [31:0] v;
    s  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    er = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we);
    a  = int'(addr % NBYTES);
    rd = 32'h0;
    if (er) begin
      lat = 2;
    end else begin
      lat = ((a % 4) + s > 4) ? 3 : 2;
      v = 32'h0;
      for (int i = 0; i < s; i++) begin
        if (we) ref_mem[(a + i) % NBYTES] = wdata[8*i +: 8];
        else    v[8*i +: 8] = ref_mem[(a + i) % NBYTES];
      end
      if (!we) rd = v << (32 - 8 * s);
    end
  endtask

  // Drive one request, wait for its response, check handshake timing
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic er, output int lat);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: req_ready never rose");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs to confirm the unit works from latched fields
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      chk("ready_low_busy", 32'(req_ready), 32'h0);
      @(negedge clk);
      lat++;
    end
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid not seen within %0d cycles", lat);
    end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    chk("valid_one_cycle", 32'(resp_valid), 32'h0);
    chk("ready_after_done", 32'(req_ready), 32'h1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic [31:0] mrd;
    logic        er;
    logic        mer;
    int          lat;
    int          mlat;
    logic [31:0] a;
    int          exp_lat;
    int          s;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h1);
    chk("reset_valid", 32'(resp_valid), 32'h0);
    chk("reset_rdata", resp_rdata, 32'h0);
    chk("reset_err", 32'(resp_err), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Prefill the regions used by the bench so no load sees undefined RAM
    for (int w = 0; w < 32; w++) begin
      a = 32'(4 * w);
      do_req(1'b1, 3'b010, a, 32'h0, rd, er, lat);
      ref_access(1'b1, 3'b010, a, 32'h0, mrd, mer, mlat);
      a = 32'(NBYTES - 128 + 4 * w);
      do_req(1'b1, 3'b010, a, 32'h0, rd, er, lat);
      ref_access(1'b1, 3'b010, a, 32'h0, mrd, mer, mlat);
    end

    vecs.push_back('{1'b1, 3'b010, 32'h10,  32'hAABBCCDD, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hAABBCCDD, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h10,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'b000, 32'h13,  32'h5555557F, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'h7F223344, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h13,  32'h0,        32'h7F000000, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'h7F220000, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h12,  32'h0,        32'h7F220000, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h0E,  32'h01020304, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0E,  32'h0,        32'h01020304, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h0E,  32'h0,        32'h04000000, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h11,  32'h0,        32'h01000000, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'h7F220102, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'hFFF, 32'h1234BEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'hFFF, 32'h0,        32'hBEEF0000, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h0,   32'h0,        32'hBE000000, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'hFFF, 32'h0,        32'hEF000000, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b111, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'h7F220102, 1'b0});

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      ref_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mer, mlat);
      s = (vecs[i].f3[1:0] == 2'b00) ? 1 : (vecs[i].f3[1:0] == 2'b01) ? 2 : 4;
      exp_lat = (!vecs[i].exp_err && (int'(vecs[i].addr[1:0]) + s > 4)) ? 3 : 2;
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    // Crossing store interrupted by reset while in W1
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h1E;
    req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_w0_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    chk("rst_mid_w1_valid", 32'(resp_valid), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'h0);
    ref_mem[32'h1E] = 8'hBE;
    ref_mem[32'h1F] = 8'hBA;
    do_req(1'b0, 3'b010, 32'h1C, 32'h0, rd, er, lat);
    ref_access(1'b0, 3'b010, 32'h1C, 32'h0, mrd, mer, mlat);
    chk("rst_mid_w0_word", rd, mrd);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    ref_access(1'b0, 3'b010, 32'h20, 32'h0, mrd, mer, mlat);
    chk("rst_mid_w1_word", rd, mrd);

    // Random traffic confined to prefilled regions, with junk upper address bits
    for (int n = 0; n < 300; n++) begin
      logic       we;
      logic [2:0] f3;
      logic [31:0] wd;
      we = 1'($urandom);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
           3'($urandom_range(0, 2)) | ((!we && $urandom_range(0, 3) == 0) ? 3'b100 : 3'b000);
      if (f3[2] && f3[1]) f3 = 3'b110;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 120))
                                     : 32'($urandom_range(NBYTES - 8, NBYTES - 1));
      a = a | ($urandom << 12);
      wd = $urandom;
      do_req(we, f3, a, wd, rd, er, lat);
      ref_access(we, f3, a, wd, mrd, mer, mlat);
      chk($sformatf("rand%0d_rdata", n), rd, mrd);
      chk($sformatf("rand%0d_err", n), 32'(er), 32'(mer));
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(mlat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
